// File: rtl/tick_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tick_div_ctrl_pkg
//  Purpose  : Shared types and constants for the divide-by-N tick controller.
//             Holds the controller state encoding, the post-reset divisor,
//             the divisor floor and the run-mode encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package tick_div_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Divisor loaded at reset, and the smallest divisor that still yields a
   // one-cycle-wide pulse followed by at least one low cycle.
   localparam int DIV_DEFAULT = 4;
   localparam int DIV_MIN     = 2;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

endpackage : tick_div_ctrl_pkg
`default_nettype wire

// File: rtl/tick_div_ctrl_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Programmable modulo-N phase counter. Counts 0 .. modulus-1
//             while enabled and wraps to zero; clear forces zero and wins
//             over enable.
//  Ports    : clk      - system clock
//             reset    - asynchronous, active-high reset
//             clear    - synchronous clear to zero
//             enable   - advance the count this cycle
//             modulus  - period N (expected >= 2)
//             count    - current phase
//             wrap     - count is sitting at its wrap point (zero)
//  Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] modulus,
   output logic [W-1:0] count,
   output logic         wrap
);

   logic at_last;

   // ">=" rather than "==" so a count that somehow exceeds the modulus
   // still folds back to zero instead of running through the full range.
   assign at_last = (count >= (modulus - W'(1)));
   assign wrap    = (count == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= at_last ? '0 : count + W'(1);
      end
   end

endmodule : mod_counter
`default_nettype wire

// File: rtl/tick_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tick_div_ctrl
//  Purpose  : Controller for a divide-by-N tick. Emits a one-cycle pulse on
//             y every div cycles, either continuously or for a counted burst,
//             with a valid/ready config handshake, start/stop, a done pulse
//             and a saturating count of emitted ticks.
//  Ports    : clk        - system clock
//             reset      - asynchronous, active-high reset
//             cfg_valid  - configuration offer
//             cfg_ready  - configuration accepted (IDLE only)
//             cfg_div    - divisor N (0 and 1 clamp to 2)
//             cfg_burst  - pulse count for burst mode
//             cfg_mode   - 0 continuous, 1 burst
//             start      - begin a run (sampled in IDLE)
//             stop       - abort a run (honoured in RUN)
//             y          - divided tick, one cycle wide
//             busy       - controller not idle
//             done       - one-cycle burst completion pulse
//             tick_count - ticks emitted in the current or last run
//  Revision : 1.0 - initial release
// ============================================================================
module tick_div_ctrl
   import tick_div_ctrl_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CNT_W-1:0]   cfg_div,
   input  logic [BURST_W-1:0] cfg_burst,
   input  logic               cfg_mode,
   input  logic               start,
   input  logic               stop,
   output logic               y,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] tick_count
);

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     div_r;
   logic [BURST_W-1:0]   burst_r;
   logic                 mode_r;
   logic [CNT_W-1:0]     phase;
   logic                 phase_zero;

   logic                 accept;
   logic                 launch;
   logic                 run_mode;
   logic [BURST_W-1:0]   run_burst;
   logic [CNT_W-1:0]     div_clamped;
   logic                 tick;
   logic                 last_pulse;

   assign accept      = cfg_valid && (state == IDLE);
   assign launch      = start && (state == IDLE);
   assign div_clamped = (cfg_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : cfg_div;

   // A config accepted on the same edge as start governs that run.
   assign run_mode    = accept ? cfg_mode  : mode_r;
   assign run_burst   = accept ? cfg_burst : burst_r;

   assign tick        = (state == RUN) && phase_zero;

   // The tick carrying the burst_r-th pulse ends the burst. tick_count can
   // never have saturated before that pulse because burst_r fits BURST_W.
   assign last_pulse  = (mode_r == MODE_BURST) && tick
                        && (tick_count == (burst_r - BURST_W'(1)));

   mod_counter #(
      .W (CNT_W)
   ) u_phase (
      .clk     (clk),
      .reset   (reset),
      .clear   (launch),
      .enable  (state == RUN),
      .modulus (div_r),
      .count   (phase),
      .wrap    (phase_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      y         = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      cfg_ready = 1'b0;

      unique case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (start) begin
               // An empty burst skips RUN entirely so no tick escapes.
               state_nxt = ((run_mode == MODE_BURST) && (run_burst == '0)) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            y    = tick;
            // stop outranks burst completion: an aborted run never signals done.
            if (stop) begin
               state_nxt = IDLE;
            end else if (last_pulse) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_r   <= CNT_W'(DIV_DEFAULT);
         burst_r <= '0;
         mode_r  <= MODE_CONT;
      end else if (accept) begin
         div_r   <= div_clamped;
         burst_r <= cfg_burst;
         mode_r  <= cfg_mode;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_count <= '0;
      end else if (launch) begin
         tick_count <= '0;
      end else if (tick && (tick_count != '1)) begin
         tick_count <= tick_count + BURST_W'(1);
      end
   end

endmodule : tick_div_ctrl
`default_nettype wire
